inference_sequencer: RTL

Top-level sequencer for one MNIST inference. On a host Start it copies a 784-pixel image from image RAM into the network input buffer and runs the forward-propagation state machine through its Compute/R handshake. It then scans the 10 output neurons and reports the arg-max digit. It sits between the host-facing registers and the network state machine.

---
 rtl/inference_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/inference_sequencer.sv
// Sequencer for one MNIST inference: image copy, network handshake, arg-max scan.
// Optional watchdog on the network handshake is enabled by defining INFER_TIMEOUT_EN.
module inference_sequencer #(
  parameter int N_PIXELS = 784,
  parameter int N_OUT    = 10,
  parameter int PIX_W    = 8,
  parameter int ADDR_W   = 10,
  parameter int VAL_W    = 16,
  parameter int TIMEOUT  = 4095
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  output logic [ADDR_W-1:0]       ImgAddr,
  input  logic [PIX_W-1:0]        ImgData,
  output logic                    BufWe,
  output logic [ADDR_W-1:0]       BufAddr,
  output logic [PIX_W-1:0]        BufData,
  output logic                    Compute,
  input  logic                    R,
  output logic [3:0]              OutSel,
  input  logic signed [VAL_W-1:0] OutVal,
  output logic [3:0]              Digit,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Error,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ARM    = 3'd2,
    S_WAIT_R = 3'd3,
    S_SCAN   = 3'd4,
    S_REPORT = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(N_PIXELS - 1);
  localparam logic [3:0]        LAST_SEL = 4'(N_OUT - 1);

  state_t state, state_next;

  logic [ADDR_W-1:0]       img_addr;
  logic                    rd_valid;
  logic                    buf_we;
  logic [ADDR_W-1:0]       buf_addr;
  logic [PIX_W-1:0]        buf_data;
  logic                    compute;
  logic                    busy;
  logic                    done;
  logic [3:0]              out_sel;
  logic                    sel_valid;
  logic                    cmp_valid;
  logic [3:0]              cmp_idx;
  logic signed [VAL_W-1:0] cmp_val;
  logic signed [VAL_W-1:0] best_val;
  logic [3:0]              best_idx;
  logic [3:0]              digit;
  logic                    wd_expire;
  logic                    timed_out;

  assign ImgAddr   = img_addr;
  assign BufWe     = buf_we;
  assign BufAddr   = buf_addr;
  assign BufData   = buf_data;
  assign Compute   = compute;
  assign OutSel    = out_sel;
  assign Digit     = digit;
  assign Busy      = busy;
  assign Done      = done;
  assign dbg_state = state;

`ifdef INFER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            waiting;
  logic            error;

  assign waiting   = (state == S_ARM) || (state == S_WAIT_R);
  // Expire on the cycle the count would land on TIMEOUT, so exactly TIMEOUT cycles are spent waiting.
  assign wd_expire = waiting && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign timed_out = error;
  assign Error     = error;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wd_cnt <= '0;
      error  <= 1'b0;
    end else begin
      wd_cnt <= waiting ? wd_cnt + WD_W'(1) : '0;
      if ((state == S_IDLE) && Start) begin
        error <= 1'b0;
      end else if (wd_expire) begin
        error <= 1'b1;
      end
    end
  end
`else
  assign wd_expire = 1'b0;
  assign timed_out = 1'b0;
  assign Error     = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (Start) state_next = S_FETCH;
      S_FETCH:  if (!rd_valid) state_next = S_ARM;
      // A stale R=1 from the previous run must clear before the real done is accepted.
      S_ARM: begin
        if (wd_expire) state_next = S_REPORT;
        else if (!R)   state_next = S_WAIT_R;
      end
      S_WAIT_R: begin
        if (wd_expire) state_next = S_REPORT;
        else if (R)    state_next = S_SCAN;
      end
      S_SCAN:   if (cmp_valid && (cmp_idx == LAST_SEL)) state_next = S_REPORT;
      S_REPORT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      img_addr  <= '0;
      rd_valid  <= 1'b0;
      buf_we    <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      compute   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_sel   <= '0;
      sel_valid <= 1'b0;
      cmp_valid <= 1'b0;
      cmp_idx   <= '0;
      cmp_val   <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      digit     <= '0;
    end else begin
      state   <= state_next;
      busy    <= (state_next != S_IDLE);
      compute <= (state_next == S_ARM) || (state_next == S_WAIT_R);
      done    <= (state == S_REPORT);
      buf_we  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            img_addr <= '0;
            rd_valid <= 1'b1;
          end
        end
        S_FETCH: begin
          // ImgData for img_addr is captured here, so the write trails the read by one cycle.
          if (rd_valid) begin
            buf_we   <= 1'b1;
            buf_addr <= img_addr;
            buf_data <= ImgData;
            if (img_addr == LAST_PIX) rd_valid <= 1'b0;
            else                      img_addr <= img_addr + ADDR_W'(1);
          end
        end
        S_WAIT_R: begin
          if (state_next == S_SCAN) begin
            out_sel   <= '0;
            sel_valid <= 1'b1;
            cmp_valid <= 1'b0;
          end
        end
        S_SCAN: begin
          if (sel_valid) begin
            if (out_sel == LAST_SEL) sel_valid <= 1'b0;
            else                     out_sel   <= out_sel + 4'd1;
          end
          cmp_valid <= sel_valid;
          cmp_idx   <= out_sel;
          cmp_val   <= OutVal;
          // Strict greater-than keeps the lowest index on ties; index 0 seeds the max.
          if (cmp_valid && ((cmp_idx == 4'd0) || (cmp_val > best_val))) begin
            best_val <= cmp_val;
            best_idx <= cmp_idx;
          end
        end
        S_REPORT: begin
          if (!timed_out) digit <= best_idx;
        end
        default: ;
      endcase
    end
  end

endmodule
